// File: rtl/mem_pkg.sv
// mem_pkg: size codes, FSM states and size legality shared by the data-memory responder.
`timescale 1ns/1ps
package mem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic is_legal_size(input logic [2:0] size);
        return size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: little-endian lane selection, byte enables, store replication and load extension.
`timescale 1ns/1ps
module mem_align
    import mem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sx;

    always_comb begin
        b        = rword[{lo, 3'b000} +: 8];
        h        = lo[1] ? rword[31:16] : rword[15:0];
        sx       = !size[2];
        misalign = (size[1:0] == 2'b01 && lo[0]) || (size[1:0] == 2'b10 && lo != 2'b00);
        be       = size[1:0] == 2'b00 ? 4'b0001 << lo :
                   size[1:0] == 2'b01 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // Replicating the data across lanes lets the byte enables alone pick the target lane
        wword    = size[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                   size[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        rdata    = size[1:0] == 2'b00 ? {{24{sx & b[7]}}, b} :
                   size[1:0] == 2'b01 ? {{16{sx & h[15]}}, h} : rword;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with valid/ready request and response handshakes.
`timescale 1ns/1ps
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      st, st_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, enter, err, misalign, mem_wr;
    logic        c_we;
    logic [2:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic [AW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wword, ld_data;

    assign req_ready = st == IDLE;
    assign rsp_valid = st == RESP;
    assign accept    = req_valid && req_ready;

    // With LATENCY==1 the response is built on the accepting edge, before the registers load
    assign c_we    = st == IDLE ? req_we    : r_we;
    assign c_size  = st == IDLE ? req_size  : r_size;
    assign c_addr  = st == IDLE ? req_addr  : r_addr;
    assign c_wdata = st == IDLE ? req_wdata : r_wdata;
    assign idx     = c_addr[AW+1:2];
    assign err     = !is_legal_size(c_size) || misalign || (c_addr[31:2] >= 30'(DEPTH_WORDS));
    assign mem_wr  = enter && c_we && !err && rst;

    mem_align u_align (
        .size     (c_size),
        .lo       (c_addr[1:0]),
        .wdata    (c_wdata),
        .rword    (mem[idx]),
        .be       (be),
        .wword    (wword),
        .rdata    (ld_data),
        .misalign (misalign)
    );

    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        enter  = 1'b0;
        case (st)
            IDLE: if (req_valid) begin
                cnt_nx = 4'(LATENCY - 1);
                st_nx  = LATENCY == 1 ? RESP : WAIT;
                enter  = LATENCY == 1;
            end
            WAIT: begin
                cnt_nx = cnt - 4'(cnt != 4'd0);
                st_nx  = cnt == 4'd0 ? RESP : WAIT;
                enter  = cnt == 4'd0;
            end
            RESP: st_nx = rsp_ready ? IDLE : RESP;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            cnt       <= '0;
            r_we      <= 1'b0;
            r_size    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
            if (accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (enter) begin
                rsp_err   <= err;
                rsp_rdata <= (err || c_we) ? '0 : ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr)
            for (int i = 0; i < 4; i++)
                if (be[i])
                    mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed stimulus checked every cycle against a byte-array memory model.
`timescale 1ns/1ps
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_size = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    logic        lit_chk = 1'b0, lit_err = 1'b0;
    logic [31:0] lit_rdata = '0;

    int nv = 0, nf = 0, cyc = 0, acc_edge = 0;
    bit busy = 0, have = 0;
    logic [31:0] er;
    logic        ee;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] lr;
        logic        le;
    } req_t;
    req_t q[$];
    logic [7:0] mb [4096];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        nv++;
        if (a !== e) begin
            nf++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
        end
    endtask

    // Reference: a byte-addressed memory; size gives the byte count, alignment is addr % count
    function automatic void model(input req_t r, output logic [31:0] rd, output logic e);
        int n;
        logic [31:0] v;
        n = r.size[1:0] == 2'b00 ? 1 : r.size[1:0] == 2'b01 ? 2 : 4;
        e = !(r.size inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (r.addr % n != 0) || (r.addr / 4 >= DEPTH);
        rd = '0;
        if (!e) begin
            if (r.we) begin
                for (int i = 0; i < n; i++) mb[r.addr + i] = r.wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (32'(mb[r.addr + i]) << (8*i));
                if (!r.size[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                rd = v;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
            q.delete();
            busy = 0;
            have = 0;
        end else begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, busy && (cyc - acc_edge >= LAT)});
            if (rsp_valid && busy) begin
                if (!have) begin
                    model(q[0], er, ee);
                    have = 1;
                end
                chk("rsp_rdata", rsp_rdata, er);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});
                if (q[0].chk) begin
                    chk("lit_rdata", rsp_rdata, q[0].lr);
                    chk("lit_err", {31'd0, rsp_err}, {31'd0, q[0].le});
                end
                if (rsp_ready) begin
                    void'(q.pop_front());
                    busy = 0;
                    have = 0;
                end
            end else if (req_valid && !busy) begin
                q.push_back('{req_we, req_size, req_addr, req_wdata, lit_chk, lit_rdata, lit_err});
                busy = 1;
                acc_edge = cyc + 1;
            end
        end
    end

    task automatic setreq(input logic we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] lr, input logic le);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        lit_chk   = 1'b1;
        lit_rdata = lr;
        lit_err   = le;
    endtask

    task automatic accept();
        int n = 0;
        logic got;
        do begin
            got = req_ready;
            @(posedge clk) #1;
            n++;
        end while (!got && n < 50);
        req_valid = 1'b0;
        if (!got) begin
            nf++;
            $display("FAIL accept_timeout: req_ready %b after %0d cycles, required 1", req_ready, n);
        end
    endtask

    task automatic respond(input int hold);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk) #1;
            n++;
        end
        if (!rsp_valid) begin
            nf++;
            $display("FAIL rsp_timeout: rsp_valid %b after %0d cycles, required 1", rsp_valid, n);
        end
        repeat (hold) @(posedge clk) #1;
        rsp_ready = 1'b1;
        @(posedge clk) #1;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] lr, input logic le);
        setreq(we, sz, a, wd, lr, le);
        accept();
        respond(0);
    endtask

    initial begin
        foreach (mb[i]) mb[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk) #1;

        xact(1, SZ_W,  32'h10, 32'h8000_00F1, 32'h0, 0);
        xact(0, SZ_W,  32'h10, 32'h0,         32'h8000_00F1, 0);
        xact(0, SZ_B,  32'h10, 32'h0,         32'hFFFF_FFF1, 0);
        xact(0, SZ_BU, 32'h10, 32'h0,         32'h0000_00F1, 0);
        xact(0, SZ_H,  32'h12, 32'h0,         32'hFFFF_8000, 0);
        xact(0, SZ_HU, 32'h12, 32'h0,         32'h0000_8000, 0);

        xact(1, SZ_B,  32'h11, 32'hFFFF_FFAB, 32'h0, 0);
        xact(0, SZ_W,  32'h10, 32'h0,         32'h8000_ABF1, 0);
        xact(0, SZ_B,  32'h11, 32'h0,         32'hFFFF_FFAB, 0);
        xact(0, SZ_H,  32'h10, 32'h0,         32'hFFFF_ABF1, 0);

        xact(0, SZ_W,  32'h12,   32'h0,         32'h0, 1);
        xact(1, SZ_H,  32'h13,   32'h0000_BEEF, 32'h0, 1);
        xact(1, 3'b011, 32'h10,  32'hDEAD_BEEF, 32'h0, 1);
        xact(0, SZ_W,  32'h1000, 32'h0,         32'h0, 1);
        xact(1, SZ_W,  32'h1000, 32'h5555_5555, 32'h0, 1);
        xact(0, SZ_W,  32'h10,   32'h0,         32'h8000_ABF1, 0);

        // Long stall in RESP with the next request already waiting
        setreq(0, SZ_W, 32'h10, 32'h0, 32'h8000_ABF1, 0);
        accept();
        while (!rsp_valid) @(posedge clk) #1;
        setreq(0, SZ_BU, 32'h11, 32'h0, 32'h0000_00AB, 0);
        repeat (5) @(posedge clk) #1;
        rsp_ready = 1'b1;
        @(posedge clk) #1;
        rsp_ready = 1'b0;
        accept();
        respond(0);

        // Reset during WAIT must drop the pending store
        xact(1, SZ_W, 32'h20, 32'h0, 32'h0, 0);
        setreq(1, SZ_W, 32'h20, 32'h1234_5678, 32'h0, 0);
        accept();
        rst = 1'b0;
        repeat (2) @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        xact(0, SZ_W, 32'h20, 32'h0, 32'h0, 0);

        @(posedge clk) #1;
        $display("== %0d vectors applied, %0d miscompares ==", nv, nf);
        $finish;
    end

endmodule
